// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared CLINT offsets, response codes, state encoding and helpers
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRESP = 2'd1,
        RRESP = 2'd2
    } clint_state_t;

    typedef enum logic [1:0] {
        REG_NONE     = 2'd0,
        REG_MSIP     = 2'd1,
        REG_MTIMECMP = 2'd2,
        REG_MTIME    = 2'd3
    } clint_reg_t;

    // Replace only the byte lanes selected by strb.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Map an address (upper half and doubleword index) to a CLINT register.
    function automatic clint_reg_t decode(input logic [15:0] addr_hi,
                                          input logic [12:0] dw_idx,
                                          input logic [15:0] base_hi);
        logic [15:0] off;
        off = {dw_idx, 3'b000};
        if (addr_hi != base_hi) begin
            return REG_NONE;
        end
        case (off)
            CLINT_MSIP_OFF:     return REG_MSIP;
            CLINT_MTIMECMP_OFF: return REG_MTIMECMP;
            CLINT_MTIME_OFF:    return REG_MTIME;
            default:            return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// rtl/clint_mtime_counter.sv - mtime register with byte-masked write port and optional prescaler (CLINT_MTIME_PRESCALE_EN)
module clint_mtime_counter
    import clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb,
    output logic [63:0] mtime
);

    logic        tick;
    logic [63:0] mtime_inc;

`ifdef CLINT_MTIME_PRESCALE_EN
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] pre_cnt;
    logic          mtime_written;

    assign mtime_written = wr_en & (|wr_strb);
    assign tick          = (pre_cnt == CW'(PRESCALE - 1));

    // Prescale counter: wraps on each tick and restarts whenever software writes mtime.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (mtime_written || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_prescale;

    assign unused_prescale = 32'(PRESCALE);
    assign tick            = 1'b1;
`endif

    assign mtime_inc = mtime + {63'd0, tick};

    // mtime advances each tick; written bytes override the increment, others keep it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= 64'd0;
        end else if (wr_en) begin
            mtime <= byte_merge(mtime_inc, wr_data, wr_strb);
        end else begin
            mtime <= mtime_inc;
        end
    end

endmodule

// File: rtl/axi_clint_slave.sv
// rtl/axi_clint_slave.sv - single-beat AXI4 CLINT responder (msip, mtimecmp, mtime); optional CLINT_MTIME_PRESCALE_EN
module axi_clint_slave
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awsize,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [63:0] s_wdata,
    input  logic [7:0]  s_wstrb,
    input  logic        s_wlast,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arsize,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [63:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [63:0] rdtime,
    output logic        int_m_timer,
    output logic        int_m_software
);

    clint_state_t state, next_state;
    clint_reg_t   wr_sel, rd_sel;

    logic        wr_acc, rd_acc;
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [63:0] rd_value;
    logic [1:0]  bresp_q, rresp_q;
    logic [63:0] rdata_q;
    logic        timer_q;
    logic        unused_ok;

    assign unused_ok = ^{s_awsize, s_arsize, s_wlast, s_awaddr[2:0], s_araddr[2:0], BASE_ADDR[15:0]};

    assign wr_sel = decode(s_awaddr[31:16], s_awaddr[15:3], BASE_ADDR[31:16]);
    assign rd_sel = decode(s_araddr[31:16], s_araddr[15:3], BASE_ADDR[31:16]);

    // State register; reset abandons any pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Accept logic and next state: a complete write (AW+W) beats a concurrent read.
    always_comb begin
        next_state = state;
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (s_awvalid && s_wvalid) begin
                        wr_acc     = 1'b1;
                        next_state = WRESP;
                    end else if (s_arvalid) begin
                        rd_acc     = 1'b1;
                        next_state = RRESP;
                    end
                end
            end
            WRESP: begin
                if (s_bready) begin
                    next_state = IDLE;
                end
            end
            RRESP: begin
                if (s_rready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign s_awready = wr_acc;
    assign s_wready  = wr_acc;
    assign s_arready = rd_acc;
    assign s_bvalid  = (state == WRESP);
    assign s_rvalid  = (state == RRESP);
    assign s_bresp   = bresp_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign s_rlast   = 1'b1;

    clint_mtime_counter #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc && (wr_sel == REG_MTIME)),
        .wr_data (s_wdata),
        .wr_strb (s_wstrb),
        .mtime   (mtime)
    );

    // Read mux over current (pre-increment) register contents.
    always_comb begin
        rd_value = 64'd0;
        case (rd_sel)
            REG_MSIP:     rd_value = {63'd0, msip};
            REG_MTIMECMP: rd_value = mtimecmp;
            REG_MTIME:    rd_value = mtime;
            default:      rd_value = 64'd0;
        endcase
    end

    // Software-interrupt bit and timer compare register, committed in the write accept cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msip     <= 1'b0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_acc) begin
            if (wr_sel == REG_MSIP && s_wstrb[0]) begin
                msip <= s_wdata[0];
            end
            if (wr_sel == REG_MTIMECMP) begin
                mtimecmp <= byte_merge(mtimecmp, s_wdata, s_wstrb);
            end
        end
    end

    // Response registers, loaded on accept and held while the response waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bresp_q <= AXI_RESP_OKAY;
            rresp_q <= AXI_RESP_OKAY;
            rdata_q <= 64'd0;
        end else begin
            if (wr_acc) begin
                bresp_q <= (wr_sel == REG_NONE) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            end
            if (rd_acc) begin
                rresp_q <= (rd_sel == REG_NONE) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                rdata_q <= rd_value;
            end
        end
    end

    // Timer interrupt is a registered level compare, never latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= 1'b0;
        end else begin
            timer_q <= (mtime >= mtimecmp);
        end
    end

    assign rdtime         = mtime;
    assign int_m_timer    = timer_q;
    assign int_m_software = msip;

endmodule
